// File: rtl/parity_block_collector_if.sv
// Handshake bundle between the parity block collector and its neighbours.
// The master modport is the collector side: it takes accumulator beats and
// produces assembled parity blocks. The slave modport is the environment.
// With PARITY_BLK_CHK_EN defined the bundle also carries the registered
// block XOR check bit blk_chk.
interface parity_block_collector_if #(
    parameter int unsigned LM   = 16,
    parameter int unsigned Z    = 256,
    parameter int unsigned NBLK = 4
);
    localparam int unsigned IdxW = (NBLK > 1) ? $clog2(NBLK) : 1;

    logic            frame_start;
    logic            in_valid;
    logic            in_ready;
    logic [LM-1:0]   par_in;
    logic            out_valid;
    logic            out_ready;
    logic [Z-1:0]    blk_out;
    logic [IdxW-1:0] blk_idx;
    logic            out_last;
`ifdef PARITY_BLK_CHK_EN
    logic            blk_chk;

    modport master (
        input  frame_start, in_valid, par_in, out_ready,
        output in_ready, out_valid, blk_out, blk_idx, out_last, blk_chk
    );

    modport slave (
        output frame_start, in_valid, par_in, out_ready,
        input  in_ready, out_valid, blk_out, blk_idx, out_last, blk_chk
    );
`else
    modport master (
        input  frame_start, in_valid, par_in, out_ready,
        output in_ready, out_valid, blk_out, blk_idx, out_last
    );

    modport slave (
        output frame_start, in_valid, par_in, out_ready,
        input  in_ready, out_valid, blk_out, blk_idx, out_last
    );
`endif

endinterface

// File: rtl/parity_block_collector.sv
// Parity block collector: packs Z/LM beats of LM accumulator bits into one
// Z-bit circulant block (beat-major, beat k lands in bits [k*LM +: LM]),
// then holds it on a valid/ready handshake. Blocks are counted per codeword
// and the block with index NBLK-1 is flagged with out_last.
// frame_start restarts the codeword and drops any partial or held block.
// Optional feature, macro PARITY_BLK_CHK_EN: adds blk_chk, the XOR of all
// bits of blk_out, accumulated beat by beat and registered with out_valid.
// Z must be a multiple of LM.
module parity_block_collector #(
    parameter int unsigned LM   = 16,
    parameter int unsigned Z    = 256,
    parameter int unsigned NBLK = 4
) (
    input logic                     clk,
    input logic                     rst,
    parity_block_collector_if.master bus
);

    localparam int unsigned Beats = Z / LM;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned IdxW  = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IdxW-1:0]  blk_cnt_q, blk_cnt_d;
    logic [Z-1:0]     buf_q, buf_d;
    logic             out_valid_q, out_valid_d;
    logic [IdxW-1:0]  blk_idx_q, blk_idx_d;
    logic             out_last_q, out_last_d;

    logic accept;
    logic last_beat;

    // Ready is purely state based so upstream never sees a loop through in_valid.
    assign bus.in_ready = (state_q == StFill) && !bus.frame_start && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = (beat_cnt_q == BeatW'(Beats - 1));

    assign bus.out_valid = out_valid_q;
    assign bus.blk_out   = buf_q;
    assign bus.blk_idx   = blk_idx_q;
    assign bus.out_last  = out_last_q;

    // Write the accepted beat into its lane group; other bits keep their value.
    always_comb begin
        buf_d = buf_q;
        for (int b = 0; b < int'(Beats); b++) begin
            if (accept && (beat_cnt_q == BeatW'(b))) begin
                buf_d[b*LM +: LM] = bus.par_in;
            end
        end
    end

    // Next-state logic for the FILL/HOLD controller and the block counters.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        out_valid_d = out_valid_q;
        blk_idx_d   = blk_idx_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    if (last_beat) begin
                        beat_cnt_d  = '0;
                        state_d     = StHold;
                        out_valid_d = 1'b1;
                        blk_idx_d   = blk_cnt_q;
                        out_last_d  = (blk_cnt_q == IdxW'(NBLK - 1));
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = StFill;
                    out_valid_d = 1'b0;
                    beat_cnt_d  = '0;
                    blk_cnt_d   = (blk_cnt_q == IdxW'(NBLK - 1)) ? '0 : blk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase

        // Codeword restart overrides everything, including a same-cycle handshake.
        if (bus.frame_start) begin
            state_d     = StFill;
            beat_cnt_d  = '0;
            blk_cnt_d   = '0;
            out_valid_d = 1'b0;
            blk_idx_d   = '0;
            out_last_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFill;
            beat_cnt_q  <= '0;
            blk_cnt_q   <= '0;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            blk_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            blk_idx_q   <= blk_idx_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef PARITY_BLK_CHK_EN
    logic chk_acc_q, chk_acc_d;
    logic blk_chk_q, blk_chk_d;

    assign bus.blk_chk = blk_chk_q;

    // Running XOR of the beats of the block in progress; published on the last beat.
    always_comb begin
        chk_acc_d = chk_acc_q;
        blk_chk_d = blk_chk_q;
        if (accept) begin
            if (last_beat) begin
                blk_chk_d = chk_acc_q ^ (^bus.par_in);
                chk_acc_d = 1'b0;
            end else begin
                chk_acc_d = chk_acc_q ^ (^bus.par_in);
            end
        end
        if (bus.frame_start) begin
            chk_acc_d = 1'b0;
            blk_chk_d = 1'b0;
        end
    end

    // Check-bit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_acc_q <= 1'b0;
            blk_chk_q <= 1'b0;
        end else begin
            chk_acc_q <= chk_acc_d;
            blk_chk_q <= blk_chk_d;
        end
    end
`endif

endmodule

// File: doc/parity_block_collector.md
Name: parity_block_collector

Overview:
- Downstream of the LM parallel parity accumulators in the RCE encoding block.
- Each cycle it takes the LM-bit vector of accumulator outputs and assembles Z/LM beats into one Z-bit parity circulant block.
- It presents each completed block to the codeword assembler over a valid/ready handshake.
- It counts blocks per codeword and flags the last one.

Parameters:
- LM, 16, parity bits per input beat (number of parallel accumulators)
- Z, 256, circulant size in bits; must be a multiple of LM
- NBLK, 4, parity blocks per codeword

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- frame_start  input  1  synchronous codeword restart; discards any partial block
- in_valid  input  1  par_in is valid
- in_ready  output  1  collector accepts par_in this cycle
- par_in  input  LM  parity bits from the accumulators; bit i belongs to accumulator i
- out_valid  output  1  blk_out holds a complete block
- out_ready  input  1  consumer accepts blk_out
- blk_out  output  Z  assembled parity block
- blk_idx  output  log2(NBLK) (min 1)  index of blk_out within the codeword
- out_last  output  1  blk_out is block NBLK-1

Behaviour:
- Reset (async, rst=1):
  - state=FILL, beat_cnt=0, blk_cnt=0.
  - Buffer and blk_out are all zero; out_valid=0, out_last=0, blk_idx=0.
  - in_ready is 0 while rst=1.
- States FILL and HOLD.
- in_ready = (state==FILL) && !frame_start. It is combinational and does not depend on in_valid.
- FILL:
  - Beat acceptance = in_valid && in_ready. Accepted beat k writes buffer[k*LM +: LM] = par_in; beat_cnt increments.
  - When beat k=Z/LM-1 is accepted: next cycle state=HOLD, out_valid=1, blk_out = full buffer including that beat.
  - Also that next cycle: blk_idx=blk_cnt, out_last=(blk_cnt==NBLK-1).
- HOLD:
  - blk_out, blk_idx and out_last are stable while out_valid=1 and out_ready=0.
  - in_ready=0; upstream must stall.
  - out_valid && out_ready: next cycle out_valid=0, state=FILL, beat_cnt=0. blk_cnt increments, wrapping to 0 after NBLK-1.
  - The buffer is not cleared; every bit is overwritten by the next block.
- Latency and throughput:
  - Last beat accepted at cycle t gives out_valid at t+1.
  - Handshake at t+1 (the earliest possible) gives in_ready=1 at t+2.
  - Throughput is Z/LM+1 cycles per block minimum (one bubble).
- frame_start (priority over every other event):
  - Next cycle: state=FILL, beat_cnt=0, blk_cnt=0, out_valid=0.
  - A par_in presented in the same cycle is not accepted.
  - A held block is dropped even if out_ready=1 in that cycle; no handshake is counted.
- in_valid=0 in FILL: nothing changes; there are no gaps in the bit ordering.
- rst asserted mid-block or mid-HOLD: immediate return to reset values; the partial block is lost.
- Bit ordering: blk_out[j] is parity bit j of the circulant, beat-major. Bit j comes from beat j/LM, lane j%LM.

Optional Feature:
- Macro: PARITY_BLK_CHK_EN.
- Defined:
  - Extra output port blk_chk (1 bit) = XOR reduction of all Z bits of blk_out.
  - blk_chk is registered and updated in the same cycle out_valid rises; it is computed incrementally per accepted beat.
  - Reset value 0; frame_start clears it to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then fill (LM=16, Z=256): 16 consecutive beats par_in=16'h0001<<(k%16), out_ready=1.
  - Required: out_valid rises exactly 1 cycle after beat 15.
  - Required: blk_out bit j=1 only for j=k*16+(k%16).
  - Required: blk_idx=0, out_last=0, in_ready=1 two cycles after beat 15.
- Backpressure: complete a block with par_in=16'hFFFF, hold out_ready=0 for 5 cycles.
  - Required: blk_out all ones and stable; in_ready=0 throughout.
  - Required: one cycle after out_ready=1, out_valid=0.
- Codeword sequence: 4 blocks back-to-back.
  - Required: blk_idx 0,1,2,3; out_last=1 only on block 3.
  - Required: block 5 has blk_idx=0.
- Bubbles: in_valid toggled 1/0 every cycle.
  - Required: block completes after 31 cycles and content matches the gapless case.
- frame_start: assert after 7 beats of block 2, with in_valid=1 in the same cycle.
  - Required: that beat is not accepted.
  - Required: next block needs 16 new beats and reports blk_idx=0.
  - Repeat with frame_start asserted during HOLD with out_ready=1: no block is counted.
- Async reset: assert rst mid-HOLD between clock edges.
  - Required: out_valid=0 and blk_out=0 immediately.
  - With PARITY_BLK_CHK_EN defined: a block with 3 set bits gives blk_chk=1.
